cpu_inta_sequencer: RTL and testbench

CPU-side interrupt acknowledge initiator for the 8259A PIC. It samples the PIC's asynchronous INT request and, when the core has interrupts enabled, drives the two active-low INTA pulses the PIC expects. On the second pulse it captures the 8-bit vector from the data bus and hands the vector to the core over a valid/ready handshake. It sits between the PIC's INT/INTA/D pins and the core's interrupt entry logic.

---
 rtl/pic_pkg.sv | 21 ++
 rtl/sync2.sv | 29 ++
 rtl/cpu_inta_sequencer.sv | 126 ++++++++++++
 tb/tb_cpu_inta_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A PIC project: INTA sequencer states,
// vector width and default pulse timing.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P1      = 3'd1,
    GAP     = 3'd2,
    P2      = 3'd3,
    DELIVER = 3'd4
  } inta_state_t;

  localparam int VECTOR_W    = 8;
  localparam int PULSE_W_DEF = 4;
  localparam int GAP_W_DEF   = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; reusable across
// the PIC project. Reset value selectable, 0 by default.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/cpu_inta_sequencer.sv
// CPU-side 8259A interrupt acknowledge initiator: two INTA pulses, vector
// capture on the second, valid/ready hand-off. Optional bus lock: INTA_LOCK_EN.
module cpu_inta_sequencer
  import pic_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                INT,
  input  logic [VECTOR_W-1:0] D,
  input  logic                intr_enable,
  output logic                INTA,
  output logic [VECTOR_W-1:0] vector,
  output logic                vec_valid,
  input  logic                vec_ready,
  output logic                busy,
  output logic                LOCK
);

  localparam int CNT_W = $clog2(max2(PULSE_W, GAP_W)) + 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  inta_state_t         r_state;
  inta_state_t         w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [VECTOR_W-1:0] r_vector;
  logic                w_int_sync;
  logic                w_cnt_done;
  logic                w_capture;

  sync2 #(.RST_VAL(1'b0)) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (w_int_sync)
  );

  assign w_cnt_done = (r_cnt == '0);
  assign w_capture  = (r_state == P2) && w_cnt_done;

  // Counter is reloaded on every state entry with (cycles - 1) of the new state.
  // NOTE: defaults at the top of the block keep every path assigned, so no latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_int_sync && intr_enable) begin
          w_state_nxt = P1;
          w_cnt_nxt   = PULSE_LOAD;
        end
      end
      P1: begin
        if (w_cnt_done) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (w_cnt_done) begin
          w_state_nxt = P2;
          w_cnt_nxt   = PULSE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      P2: begin
        if (w_cnt_done) begin
          w_state_nxt = DELIVER;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      DELIVER: begin
        if (vec_ready) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: the vector register is reset because it is visible on a port;
  // it otherwise holds its value until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vector <= '0;
    end else if (w_capture) begin
      r_vector <= D;
    end
  end

  assign INTA      = !((r_state == P1) || (r_state == P2));
  assign vec_valid = (r_state == DELIVER);
  assign busy      = (r_state != IDLE);
  assign vector    = r_vector;

`ifdef INTA_LOCK_EN
  assign LOCK = (r_state == P1) || (r_state == GAP) || (r_state == P2);
`else
  assign LOCK = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_inta_sequencer.sv
// Self-checking bench for cpu_inta_sequencer: directed scenarios plus random
// traffic, checked every cycle against a timeline-based behavioural model.
module tb_cpu_inta_sequencer;

  localparam int PW = 4;
  localparam int GW = 2;
  localparam int L  = 2 * PW + GW;

`ifdef INTA_LOCK_EN
  localparam int LOCK_CYCLES = L;
`else
  localparam int LOCK_CYCLES = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       INT = 1'b0;
  logic [7:0] D = 8'h00;
  logic       intr_enable = 1'b0;
  logic       vec_ready = 1'b0;
  logic       INTA;
  logic [7:0] vector;
  logic       vec_valid;
  logic       busy;
  logic       LOCK;

  int errors = 0;
  int checks = 0;

  // Model: a sequence is a timeline t = 0 .. L-1 of acknowledge cycles
  // followed by a delivery phase at t == L.
  bit         m_s1, m_s2;
  bit         m_active;
  int         m_t;
  logic [7:0] m_vec;

  cpu_inta_sequencer #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .INT         (INT),
    .D           (D),
    .intr_enable (intr_enable),
    .INTA        (INTA),
    .vector      (vector),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .busy        (busy),
    .LOCK        (LOCK)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_active = 0; m_t = 0; m_vec = 8'h00;
  endtask

  task automatic model_edge();
    bit sync;
    sync = m_s2;
    m_s2 = m_s1;
    m_s1 = INT;
    if (!m_active) begin
      if (sync && intr_enable) begin
        m_active = 1;
        m_t = 0;
      end
    end else if (m_t < L) begin
      if (m_t == L - 1) m_vec = D;
      m_t++;
    end else if (vec_ready) begin
      m_active = 0;
    end
  endtask

  task automatic compare_all();
    bit low;
    bit lock_exp;
    low = m_active && ((m_t < PW) || (m_t >= PW + GW && m_t < L));
`ifdef INTA_LOCK_EN
    lock_exp = m_active && (m_t < L);
`else
    lock_exp = 0;
`endif
    check("INTA", INTA, !low);
    check("vec_valid", vec_valid, m_active && m_t == L);
    check("busy", busy, m_active);
    check("LOCK", LOCK, lock_exp);
    check("vector", vector, m_vec);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic wait_fall(input int budget, output int n);
    n = 0;
    while (INTA !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check("inta_fall_seen", INTA, 1'b0);
  endtask

  task automatic wait_valid(input int budget, output int n, output int lock_n);
    n = 0;
    lock_n = (LOCK === 1'b1) ? 1 : 0;
    while (vec_valid !== 1'b1 && n < budget) begin
      step();
      n++;
      if (vec_valid !== 1'b1 && LOCK === 1'b1) lock_n++;
    end
    check("vec_valid_seen", vec_valid, 1'b1);
  endtask

  initial begin
    int n, ln;
    bit stable;

    model_reset();
    #2;
    compare_all();
    check("reset_INTA", INTA, 1'b1);
    check("reset_busy", busy, 1'b0);
    #11 rst_n = 1'b1;
    step();

    // Basic sequence
    D = 8'h4A; vec_ready = 1'b1; intr_enable = 1'b1; INT = 1'b1;
    wait_fall(20, n);
    check("int_to_inta_latency", n, 3);
    wait_valid(40, n, ln);
    check("fall_to_valid", n, L);
    check("basic_vector", vector, 8'h4A);
    check("lock_cycles", ln, LOCK_CYCLES);
    intr_enable = 1'b0; INT = 1'b0;
    step();
    check("valid_drops", vec_valid, 1'b0);
    repeat (3) step();

    // Masked
    INT = 1'b1;
    stable = 1;
    repeat (50) begin
      step();
      if (busy !== 1'b0 || INTA !== 1'b1) stable = 0;
    end
    check("masked_idle", stable, 1'b1);
    vec_ready = 1'b0; intr_enable = 1'b1;
    wait_fall(10, n);
    check("unmask_latency", n, 1);
    wait_valid(40, n, ln);

    // Backpressure
    intr_enable = 1'b0; INT = 1'b0;
    stable = 1;
    repeat (20) begin
      step();
      if (vec_valid !== 1'b1 || vector !== 8'h4A || INTA !== 1'b1) stable = 0;
    end
    check("backpressure_hold", stable, 1'b1);
    vec_ready = 1'b1;
    step();
    check("bp_release_valid", vec_valid, 1'b0);
    check("bp_release_busy", busy, 1'b0);
    repeat (3) step();

    // INT withdrawn during GAP: spurious IR7 vector still delivered
    D = 8'h4F; intr_enable = 1'b1; INT = 1'b1;
    wait_fall(20, n);
    repeat (PW) step();
    check("in_gap_inta_high", INTA, 1'b1);
    INT = 1'b0;
    wait_valid(40, n, ln);
    check("withdrawn_fall_to_valid", n, L - PW);
    check("spurious_vector", vector, 8'h4F);
    intr_enable = 1'b0;
    step();
    repeat (3) step();

    // Async reset in P2
    D = 8'h33; intr_enable = 1'b1; INT = 1'b1;
    wait_fall(20, n);
    repeat (PW + GW + 1) step();
    check("in_p2_inta_low", INTA, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_INTA", INTA, 1'b1);
    check("arst_valid", vec_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_LOCK", LOCK, 1'b0);
    check("arst_vector", vector, 8'h00);
    #2 rst_n = 1'b1;
    wait_fall(20, n);
    check("post_reset_latency", n, 3);
    wait_valid(40, n, ln);
    check("post_reset_fall_to_valid", n, L);
    check("post_reset_vector", vector, 8'h33);
    intr_enable = 1'b0; INT = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      INT         = ($urandom_range(0, 3) != 0);
      intr_enable = ($urandom_range(0, 2) != 0);
      vec_ready   = ($urandom_range(0, 2) != 0);
      D           = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
